pp_pipeline_accel_mac_pipe: RTL
===============================

Name: pp_pipeline_accel_mac_pipe

Overview:
- Parametrised successor to the fixed 16x16 pipelined DSP multiplier in the pp_pipeline_accel datapath.
- Adds:
  - configurable operand widths, signedness and pipeline depth;
  - a per-sample valid pipeline;
  - an optional accumulate mode, so colour-conversion and filter-tap sums run in one block.
- Sits between the pixel unpack stage and the normalisation/rounding stage; the same clock-enable stall semantics apply throughout.

Parameters:
- A_W, 16: width of operand a.
- B_W, 16: width of operand b.
- ACC_W, 40: accumulator/output width. Must be >= A_W+B_W.
- SIGNED, 0: 0 = both operands unsigned (zero-extended); 1 = both two's-complement (sign-extended).
- NUM_STAGE, 4: total latency in ce-enabled cycles. Legal range 3..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable. Low freezes every register, valid bits included.
- din_vld  in  1  sample valid
- acc_en  in  1  1 = add product to running sum; 0 = restart sum with this product. Sampled with din_vld.
- din0  in  A_W  operand a
- din1  in  B_W  operand b
- dout  out  ACC_W  accumulator value
- dout_vld  out  1  dout carries a new result
- ovf  out  1  sticky overflow flag; tied 0 when MAC_SAT_EN is undefined

Behaviour:
- Reset:
  - Synchronous, active-high, overrides ce.
  - Next edge clears every stage register, all valid bits, acc_en shadows, dout (0), dout_vld (0) and ovf (0).
  - Reset mid-operation discards all in-flight samples; no result for them ever appears.
- Stage map (NUM_STAGE = N):
  - S1: register din0, din1, din_vld, acc_en.
  - S2: full-precision product P = ext(a)*ext(b), width A_W+B_W, signed per SIGNED.
  - S3..S(N-1): pure delay registers for P, valid and acc_en.
  - SN: accumulator register.
  - N=3 has no delay stages.
- Accumulator update (SN, when ce=1 and the SN-input valid is 1):
  - acc_en=0: acc <= ext(P).
  - acc_en=1: acc <= acc + ext(P), wrapping modulo 2^ACC_W.
  - ext() to ACC_W follows SIGNED.
  - If the SN-input valid is 0, acc holds.
- Outputs:
  - dout = acc, registered.
  - dout_vld = registered SN valid: 1 for exactly one ce-enabled cycle per accepted sample, N ce-enabled cycles after din_vld was sampled.
- Stall:
  - ce=0 freezes all registers, including dout and dout_vld.
  - The consumer qualifies dout_vld with ce.
  - Inputs presented while ce=0 are not sampled.
- Throughput: one sample per ce-enabled cycle. Bubbles (din_vld=0) propagate and leave acc untouched.
- acc_en travels with its sample, so a restart (acc_en=0) takes effect exactly on that sample even with bubbles in flight.
- Width rule: for A_W+B_W == ACC_W, the non-accumulate result equals the legacy 16x16 multiplier bit-for-bit, latency N.

Optional Feature:
- Macro: PP_MAC_SAT_EN.
- Defined:
  - An accumulate that would exceed the ACC_W range clamps to max (unsigned 2^ACC_W-1; signed 2^(ACC_W-1)-1) or, for signed only, to min (-2^(ACC_W-1)).
  - ovf is set on the same edge and stays sticky until reset.
  - Non-accumulate samples cannot overflow (ACC_W >= A_W+B_W).
- Undefined: the sum wraps modulo 2^ACC_W and ovf is constant 0.

Decomposition:
- Package pp_mac_pkg holds:
  - NUM_STAGE_MIN=3 and NUM_STAGE_MAX=8;
  - a function computing ACC_W saturation bounds from (ACC_W, SIGNED);
  - an elaboration-time check function for parameter legality.
- One sub-module, pp_mac_delay_line:
  - Parametrised width/depth shift register with ce and synchronous reset.
  - Carries {P, valid, acc_en} through S3..S(N-1).
  - Depth 0 is a pass-through.

Test Plan:
- Legacy equivalence: A_W=B_W=16, ACC_W=32, SIGNED=0, N=4, acc_en=0, din0=din1=0xFFFF -> dout=0xFFFE0001 with dout_vld high exactly 4 cycles later.
- Signed: SIGNED=1, din0=-3, din1=5 -> dout=-15 sign-extended to ACC_W (0xFF_FFFF_FFF1 at ACC_W=40).
- Accumulate: back-to-back (2,3,acc_en=0), (4,5,1), (1,1,0) -> dout sequence 6, 26, 1 on consecutive dout_vld cycles. Repeat with a bubble between samples -> same values, bubble cycle dout_vld=0.
- Stall: ce low for 3 cycles mid-stream -> dout, dout_vld and all in-flight results frozen. Results resume in order with total latency of N ce-enabled cycles and no sample lost or duplicated.
- Reset mid-op: pulse reset with 3 samples in flight -> dout=0, dout_vld=0 next edge, no results from those samples ever appear. The first post-reset sample is correct.
- PP_MAC_SAT_EN: unsigned ACC_W=32, accumulate 0xFFFF*0xFFFF twice -> dout=0xFFFFFFFF, ovf=1 and stays 1. Without the macro -> dout=0xFFFC0002, ovf=0.

Source files
------------

// File: rtl/pp_mac_pkg.sv
// rtl/pp_mac_pkg.sv - shared limits, saturation bounds and parameter checks for the MAC pipeline
package pp_mac_pkg;

   localparam int NUM_STAGE_MIN = 3;
   localparam int NUM_STAGE_MAX = 8;
   localparam int ACC_W_MAX     = 128;

   typedef logic [ACC_W_MAX-1:0] sat_val_t;

   typedef struct packed {
      sat_val_t max_v;
      sat_val_t min_v;
   } sat_bounds_t;

   // Bounds are right-aligned; callers keep the low acc_w bits.
   function automatic sat_bounds_t sat_bounds(input int acc_w, input bit signed_mode);
      sat_bounds_t b;
      b.max_v = '0;
      b.min_v = '0;
      for (int i = 0; i < ACC_W_MAX; i++) begin
         if (i < acc_w) b.max_v[i] = 1'b1;
      end
      if (signed_mode) begin
         b.max_v[acc_w-1] = 1'b0;
         b.min_v[acc_w-1] = 1'b1;
      end
      return b;
   endfunction

   function automatic bit params_ok(input int a_w, input int b_w, input int acc_w,
                                    input int signed_mode, input int num_stage);
      return (a_w >= 1) && (b_w >= 1) && (acc_w >= a_w + b_w) && (acc_w <= ACC_W_MAX) &&
             (signed_mode == 0 || signed_mode == 1) &&
             (num_stage >= NUM_STAGE_MIN) && (num_stage <= NUM_STAGE_MAX);
   endfunction

endpackage

// File: rtl/pp_mac_delay_line.sv
// rtl/pp_mac_delay_line.sv - ce-gated shift register of configurable width and depth
// Depth 0 degenerates to a wire.
module pp_mac_delay_line
   import pp_mac_pkg::*;
#(
   parameter int W     = 1,
   parameter int DEPTH = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      assign dout = din;
   end else begin : g_shift
      logic [DEPTH-1:0][W-1:0] sr_q, sr_d;

      always_comb begin
         sr_d = sr_q;
         if (ce) begin
            sr_d[0] = din;
            for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) sr_q <= '0;
         else       sr_q <= sr_d;
      end

      assign dout = sr_q[DEPTH-1];
   end

endmodule

// File: rtl/pp_pipeline_accel_mac_pipe.sv
// rtl/pp_pipeline_accel_mac_pipe.sv - parametrised pipelined multiply-accumulate with ce stall
// Optional clamp-on-overflow with sticky ovf when PP_MAC_SAT_EN is defined.
module pp_pipeline_accel_mac_pipe
   import pp_mac_pkg::*;
#(
   parameter int A_W       = 16,
   parameter int B_W       = 16,
   parameter int ACC_W     = 40,
   parameter int SIGNED    = 0,
   parameter int NUM_STAGE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic             din_vld,
   input  logic             acc_en,
   input  logic [A_W-1:0]   din0,
   input  logic [B_W-1:0]   din1,
   output logic [ACC_W-1:0] dout,
   output logic             dout_vld,
   output logic             ovf
);

   localparam int P_W = A_W + B_W;
   localparam int DLY = NUM_STAGE - 3;

   if (!params_ok(A_W, B_W, ACC_W, SIGNED, NUM_STAGE)) begin : g_param_check
      $error("pp_pipeline_accel_mac_pipe: illegal parameter combination");
   end

   logic [A_W-1:0]   a_q, a_d;
   logic [B_W-1:0]   b_q, b_d;
   logic             vld1_q, vld1_d, ae1_q, ae1_d;
   logic [P_W-1:0]   p_q, p_d;
   logic             vld2_q, vld2_d, ae2_q, ae2_d;
   logic [P_W-1:0]   p_n;
   logic             vld_n, ae_n;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             dout_vld_q, dout_vld_d;
   logic [P_W-1:0]   a_x, b_x;
   logic [ACC_W-1:0] p_ext, acc_next;

   // valid and acc_en ride alongside the product so restarts stay aligned through bubbles
   pp_mac_delay_line #(
      .W     (P_W + 2),
      .DEPTH (DLY)
   ) u_dly (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .din   ({p_q, vld2_q, ae2_q}),
      .dout  ({p_n, vld_n, ae_n})
   );

`ifdef PP_MAC_SAT_EN
   localparam sat_bounds_t      SAT     = sat_bounds(ACC_W, SIGNED != 0);
   localparam logic [ACC_W-1:0] SAT_MAX = SAT.max_v[ACC_W-1:0];
   localparam logic [ACC_W-1:0] SAT_MIN = SAT.min_v[ACC_W-1:0];

   logic [ACC_W:0]   sum_x;
   logic             sat_hit;
   logic [ACC_W-1:0] sat_val;
   logic             ovf_q, ovf_d;

   always_comb begin
      sum_x = {1'b0, acc_q} + {1'b0, p_ext};
      if (SIGNED != 0) begin
         sat_hit = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum_x[ACC_W-1] != acc_q[ACC_W-1]);
         sat_val = p_ext[ACC_W-1] ? SAT_MIN : SAT_MAX;
      end else begin
         sat_hit = sum_x[ACC_W];
         sat_val = SAT_MAX;
      end
      acc_next = sat_hit ? sat_val : sum_x[ACC_W-1:0];
      ovf_d    = ovf_q | (ce & vld_n & ae_n & sat_hit);
   end

   always_ff @(posedge clk) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   always_comb begin
      acc_next = acc_q + p_ext;
   end

   assign ovf = 1'b0;
`endif

   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      vld1_d     = vld1_q;
      ae1_d      = ae1_q;
      p_d        = p_q;
      vld2_d     = vld2_q;
      ae2_d      = ae2_q;
      acc_d      = acc_q;
      dout_vld_d = dout_vld_q;
      if (SIGNED != 0) begin
         a_x   = P_W'($signed(a_q));
         b_x   = P_W'($signed(b_q));
         p_ext = ACC_W'($signed(p_n));
      end else begin
         a_x   = P_W'(a_q);
         b_x   = P_W'(b_q);
         p_ext = ACC_W'(p_n);
      end
      if (ce) begin
         a_d        = din0;
         b_d        = din1;
         vld1_d     = din_vld;
         ae1_d      = acc_en;
         p_d        = a_x * b_x;
         vld2_d     = vld1_q;
         ae2_d      = ae1_q;
         dout_vld_d = vld_n;
         if (vld_n) acc_d = ae_n ? acc_next : p_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q        <= '0;
         b_q        <= '0;
         vld1_q     <= 1'b0;
         ae1_q      <= 1'b0;
         p_q        <= '0;
         vld2_q     <= 1'b0;
         ae2_q      <= 1'b0;
         acc_q      <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         vld1_q     <= vld1_d;
         ae1_q      <= ae1_d;
         p_q        <= p_d;
         vld2_q     <= vld2_d;
         ae2_q      <= ae2_d;
         acc_q      <= acc_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   assign dout     = acc_q;
   assign dout_vld = dout_vld_q;

endmodule
